// File: rtl/ysyx_22040000_wbu_if.sv
// Upstream-to-writeback entry bus; one entry per in_valid && in_ready cycle.
// Latency/backpressure: none here, in_ready is owned by the writeback unit.
interface ysyx_22040000_wbu_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [AWIDTH-1:0] in_rd;
    logic [DWIDTH-1:0] in_alu;
    logic [DWIDTH-1:0] in_ld_data;
    logic [1:0]        in_sel;
    logic [2:0]        in_funct3;
    logic [1:0]        in_addr_lo;
    logic [DWIDTH-1:0] in_pc;

    modport master (
        output in_valid, in_rd, in_alu, in_ld_data, in_sel, in_funct3, in_addr_lo, in_pc,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_alu, in_ld_data, in_sel, in_funct3, in_addr_lo, in_pc,
        output in_ready
    );
endinterface

// File: rtl/ysyx_22040000_wbu.sv
// Writeback unit: formats results at accept, commits from head S to the register file 1 cycle later.
// Backpressure: stall holds S, a skid entry K absorbs one more; in_ready drops only while K is full.
module ysyx_22040000_wbu #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22040000_wbu_if.slave     up,
    input  logic                   stall,
    output logic                   rf_wen,
    output logic [AWIDTH-1:0]      rf_waddr,
    output logic [DWIDTH-1:0]      rf_wdata,
    output logic                   commit_valid,
    output logic [DWIDTH-1:0]      commit_pc,
    output logic [63:0]            retire_cnt,
    output logic                   ld_err
);
    typedef struct packed {
        logic              vld;
        logic [AWIDTH-1:0] rd;
        logic [DWIDTH-1:0] wdata;
        logic              wr;
        logic [DWIDTH-1:0] pc;
    } entry_t;

    entry_t s_q, k_q, s_n, k_n, new_e;

    logic              accept;
    logic              commit;
    logic              ld_illegal;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DWIDTH-1:0] ld_fmt;

    assign up.in_ready = !k_q.vld && !rst;
    assign accept      = up.in_valid && up.in_ready;
    assign commit      = s_q.vld && !stall;

    assign ld_byte = up.in_ld_data[{up.in_addr_lo, 3'b000} +: 8];
    assign ld_half = up.in_addr_lo[1] ? up.in_ld_data[31:16] : up.in_ld_data[15:0];

    always_comb begin
        ld_fmt     = '0;
        ld_illegal = 1'b0;
        case (up.in_funct3)
            3'b000:  ld_fmt = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {{(DWIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_fmt = {{(DWIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {{(DWIDTH-16){1'b0}}, ld_half};
            3'b010:  ld_fmt = up.in_ld_data;
            default: ld_illegal = 1'b1;
        endcase
    end

    always_comb begin
        new_e     = '0;
        new_e.vld = 1'b1;
        new_e.rd  = up.in_rd;
        new_e.pc  = up.in_pc;
        new_e.wr  = (up.in_sel != 2'd3);
        case (up.in_sel)
            2'd0:    new_e.wdata = up.in_alu;
            2'd1:    new_e.wdata = ld_fmt;
            2'd2:    new_e.wdata = up.in_pc + DWIDTH'(4);
            default: new_e.wdata = '0;
        endcase
    end

    // Entry movement between head and skid; accept is impossible while K is full.
    always_comb begin
        s_n = s_q;
        k_n = k_q;
        if (!s_q.vld) begin
            s_n = accept ? new_e : '0;
        end else if (commit) begin
            if (k_q.vld) begin
                s_n = k_q;
                k_n = '0;
            end else begin
                s_n = accept ? new_e : '0;
            end
        end else if (!k_q.vld && accept) begin
            k_n = new_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= '0;
            k_q        <= '0;
            retire_cnt <= '0;
            ld_err     <= 1'b0;
        end else begin
            s_q <= s_n;
            k_q <= k_n;
            if (commit) begin
                retire_cnt <= retire_cnt + 64'd1;
            end
            if (accept && up.in_sel == 2'd1 && ld_illegal) begin
                ld_err <= 1'b1;
            end
        end
    end

    assign commit_valid = commit;
    assign commit_pc    = s_q.pc;
    assign rf_wen       = commit && s_q.wr && (s_q.rd != '0);
    assign rf_waddr     = s_q.rd;
    assign rf_wdata     = s_q.wdata;
endmodule

// File: tb/tb_ysyx_22040000_wbu.sv
// Directed and random stimulus against an in-order queue model of the writeback unit.
module tb_ysyx_22040000_wbu;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [63:0] retire_cnt;
    logic        ld_err;

    ysyx_22040000_wbu_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

    ysyx_22040000_wbu #(.DWIDTH(32), .AWIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .up           (bus),
        .stall        (stall),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .retire_cnt   (retire_cnt),
        .ld_err       (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata;
        bit          wr;
        logic [31:0] pc;
    } ment_t;

    ment_t       q[$];
    longint      mcnt;
    bit          merr;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result value derived straight from the sel/funct3 rules with integer arithmetic.
    function automatic logic [31:0] ref_wdata(input logic [1:0] sel, input logic [31:0] alu,
                                              input logic [31:0] ld, input logic [31:0] pc,
                                              input logic [2:0] f3, input logic [1:0] lo);
        int unsigned b;
        int unsigned h;
        int unsigned lo_i;
        lo_i = 32'(lo);
        b = (ld >> (8 * lo_i)) & 32'hff;
        h = (ld >> (16 * (lo_i / 2))) & 32'hffff;
        if (sel == 2'd0) return alu;
        if (sel == 2'd2) return pc + 32'd4;
        if (sel == 2'd3) return 32'd0;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            3'd2:    return ld;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] pc, input bit st);
        bus.in_valid   = v;
        bus.in_rd      = rd;
        bus.in_alu     = alu;
        bus.in_ld_data = ld;
        bus.in_sel     = sel;
        bus.in_funct3  = f3;
        bus.in_addr_lo = lo;
        bus.in_pc      = pc;
        stall          = st;
    endtask

    task automatic idle(input bit st);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 3'd0, 2'd0, 32'd0, st);
    endtask

    task automatic tick;
        bit    exp_commit;
        bit    exp_acc;
        bit    exp_ill;
        ment_t head;
        ment_t ne;
        @(negedge clk);
        exp_commit = (q.size() > 0) && !stall;
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        chk("commit_valid", 64'(commit_valid), 64'(exp_commit));
        chk("retire_cnt", retire_cnt, 64'(mcnt));
        chk("ld_err", 64'(ld_err), 64'(merr));
        if (exp_commit) begin
            head = q[0];
            chk("commit_pc", 64'(commit_pc), 64'(head.pc));
            chk("rf_wen", 64'(rf_wen), 64'(head.wr && head.rd != 5'd0));
            chk("rf_waddr", 64'(rf_waddr), 64'(head.rd));
            if (head.wr) chk("rf_wdata", 64'(rf_wdata), 64'(head.wdata));
        end else begin
            chk("rf_wen_idle", 64'(rf_wen), 64'd0);
        end
        exp_acc = bus.in_valid && (q.size() < 2);
        exp_ill = (bus.in_sel == 2'd1) &&
                  (bus.in_funct3 == 3'd3 || bus.in_funct3 == 3'd6 || bus.in_funct3 == 3'd7);
        ne.rd    = bus.in_rd;
        ne.wr    = (bus.in_sel != 2'd3);
        ne.pc    = bus.in_pc;
        ne.wdata = ref_wdata(bus.in_sel, bus.in_alu, bus.in_ld_data, bus.in_pc,
                             bus.in_funct3, bus.in_addr_lo);
        @(posedge clk);
        #1;
        if (exp_commit) begin
            void'(q.pop_front());
            mcnt++;
        end
        if (exp_acc) begin
            q.push_back(ne);
            if (exp_ill) merr = 1'b1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_rf_wen", 64'(rf_wen), 64'd0);
            chk("rst_commit_valid", 64'(commit_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            chk("rst_retire_cnt", retire_cnt, 64'd0);
            chk("rst_ld_err", 64'(ld_err), 64'd0);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        q.delete();
        mcnt = 0;
        merr = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mcnt   = 0;
        merr   = 1'b0;
        rst    = 1'b1;
        idle(1'b0);
        do_reset();

        // Back-to-back ALU writes to x1..x4
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(i + 1), 32'h10 + 32'(i), 32'd0, 2'd0, 3'd0, 2'd0,
                  32'h1000 + 32'(4 * i), 1'b0);
            tick();
            #1;
            chk("b2b_wen", 64'(rf_wen), 64'd1);
            chk("b2b_wdata", 64'(rf_wdata), 64'h10 + 64'(i));
        end
        idle(1'b0);
        tick();
        chk("b2b_retire_cnt", retire_cnt, 64'd4);

        // Load formatting: LB byte 3 then LHU upper half of 0x80FF_0000
        drive(1'b1, 5'd5, 32'd0, 32'h80FF_0000, 2'd1, 3'b000, 2'd3, 32'h2000, 1'b0);
        tick();
        drive(1'b1, 5'd6, 32'd0, 32'h80FF_0000, 2'd1, 3'b101, 2'd2, 32'h2004, 1'b0);
        #1;
        chk("lb_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
        tick();
        idle(1'b0);
        #1;
        chk("lhu_wdata", 64'(rf_wdata), 64'h0000_80FF);
        tick();

        // Stall three cycles while two entries arrive
        drive(1'b1, 5'd7, 32'hA, 32'd0, 2'd0, 3'd0, 2'd0, 32'h3000, 1'b1);
        tick();
        drive(1'b1, 5'd8, 32'hB, 32'd0, 2'd0, 3'd0, 2'd0, 32'h3004, 1'b1);
        tick();
        idle(1'b1);
        #1;
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        idle(1'b0);
        #1;
        chk("stall_first_pc", 64'(commit_pc), 64'h3000);
        tick();
        #1;
        chk("stall_second_pc", 64'(commit_pc), 64'h3004);
        chk("stall_second_wen", 64'(rf_wen), 64'd1);
        tick();

        // x0 target and sel 3 no-write
        drive(1'b1, 5'd0, 32'h55, 32'd0, 2'd0, 3'd0, 2'd0, 32'h4000, 1'b0);
        tick();
        drive(1'b1, 5'd9, 32'h66, 32'd0, 2'd3, 3'd0, 2'd0, 32'h4004, 1'b0);
        #1;
        chk("x0_wen", 64'(rf_wen), 64'd0);
        chk("x0_commit", 64'(commit_valid), 64'd1);
        tick();
        idle(1'b0);
        #1;
        chk("nowr_wen", 64'(rf_wen), 64'd0);
        chk("nowr_commit", 64'(commit_valid), 64'd1);
        tick();
        chk("nowr_retire_cnt", retire_cnt, 64'd10);

        // Illegal load funct3 111 plus a pc+4 entry
        drive(1'b1, 5'd10, 32'd0, 32'hDEAD_BEEF, 2'd1, 3'b111, 2'd1, 32'h5000, 1'b0);
        tick();
        drive(1'b1, 5'd11, 32'd0, 32'd0, 2'd2, 3'd0, 2'd0, 32'hFFFF_FFFC, 1'b0);
        #1;
        chk("ill_wdata", 64'(rf_wdata), 64'd0);
        chk("ill_wen", 64'(rf_wen), 64'd1);
        chk("ill_ld_err", 64'(ld_err), 64'd1);
        tick();
        idle(1'b0);
        #1;
        chk("pc4_wrap", 64'(rf_wdata), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("ill_ld_err_sticky", 64'(ld_err), 64'd1);

        // Reset with S and K both occupied
        drive(1'b1, 5'd12, 32'hC, 32'd0, 2'd0, 3'd0, 2'd0, 32'h6000, 1'b1);
        tick();
        drive(1'b1, 5'd13, 32'hD, 32'd0, 2'd0, 3'd0, 2'd0, 32'h6004, 1'b1);
        tick();
        #1;
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        do_reset();
        idle(1'b0);
        tick();
        chk("post_rst_cnt", retire_cnt, 64'd0);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 5'($urandom), $urandom, $urandom,
                  2'($urandom), 3'($urandom), 2'($urandom), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 9) < 3));
            tick();
        end
        idle(1'b0);
        for (int i = 0; i < 3; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22040000_wbu.md
YSYX_22040000_WBU -- requirements
Module: ysyx_22040000_wbu

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, datapath and register width.
REQ-002 SHALL have parameter AWIDTH, default 5, register-index width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: upstream entry valid.
REQ-006 SHALL have port in_ready, output, 1: unit accepts an entry this cycle.
REQ-007 SHALL have port in_rd, input, AWIDTH: destination register index.
REQ-008 SHALL have port in_alu, input, DWIDTH: ALU result.
REQ-009 SHALL have port in_ld_data, input, DWIDTH: raw aligned memory word.
REQ-010 SHALL have port in_sel, input, 2: result source; 0 ALU, 1 load, 2 pc+4, 3 no write.
REQ-011 SHALL have port in_funct3, input, 3: load type.
REQ-012 SHALL have port in_addr_lo, input, 2: load address bits [1:0].
REQ-013 SHALL have port in_pc, input, DWIDTH: instruction PC.
REQ-014 SHALL have port stall, input, 1: hold commit this cycle.
REQ-015 SHALL have ports rf_wen (output, 1), rf_waddr (output, AWIDTH) and rf_wdata (output, DWIDTH): register-file write port.
REQ-016 SHALL have ports commit_valid (output, 1) and commit_pc (output, DWIDTH): retire pulse and PC of the retiring entry.
REQ-017 SHALL have ports retire_cnt (output, 64), retired-instruction count, and ld_err (output, 1), sticky illegal-load flag.

Function
REQ-018 SHALL hold two entry registers: stage S (head) and skid K; each entry holds valid, rd, final wdata, write flag and pc.
REQ-019 SHALL drive in_ready = !K.valid && !rst.
REQ-020 SHALL accept an entry when in_valid && in_ready.
REQ-021 SHALL compute final wdata at accept: sel 0 -> in_alu; sel 2 -> in_pc+4 (mod 2^DWIDTH); sel 1 -> formatted load; sel 3 -> no write, wdata don't-care.
REQ-022 SHALL format loads as: LB 000 / LBU 100 -> byte in_addr_lo, sign- or zero-extended; LH 001 / LHU 101 -> halfword in_addr_lo[1], in_addr_lo[0] ignored; LW 010 -> whole word, in_addr_lo ignored.
REQ-023 SHALL treat a load with funct3 011, 110 or 111 as follows: wdata = 0, write still performed, ld_err set and held until reset.
REQ-024 SHALL define commit = S.valid && !stall.
REQ-025 SHALL drive the register-file port combinationally from S: rf_wen = commit && write flag && rd != 0; rf_waddr = S.rd; rf_wdata = S.wdata.
REQ-026 SHALL assert commit_valid = commit, with commit_pc = S.pc; a sel 3 entry retires without writing.
REQ-027 SHALL increment retire_cnt by 1 on every commit cycle, wrapping from 2^64-1 to 0.
REQ-028 SHALL move entries per cycle as follows:
- S empty: accepted entry -> S.
- S committing, K empty: accepted entry -> S, else S cleared.
- S committing, K full: K -> S, K cleared (no accept possible).
- S held (stall), K empty: accepted entry -> K.
- S held, K full: no movement.
REQ-029 SHALL retire entries in strict acceptance order; no entry is dropped or duplicated.
REQ-030 SHALL sustain 1 entry/cycle throughput with stall low; accept-to-rf_wen latency is 1 cycle.

Reset
REQ-031 SHALL, while rst is high, force S.valid = K.valid = 0, retire_cnt = 0, ld_err = 0; rf_wen, commit_valid and in_ready read 0.
REQ-032 SHALL discard buffered entries on reset mid-operation with no rf write, and set in_ready = 1 in the first cycle after rst falls.

Verification
REQ-033 Bench SHALL cover back-to-back ALU writes: rd 1..4, in_alu 0x10..0x13, stall 0 -> rf_wen on 4 consecutive cycles, retire_cnt = 4.
REQ-034 Bench SHALL cover load formatting: LB, addr_lo 3, word 0x80FF_0000 -> wdata 0xFFFF_FF80; LHU, addr_lo 2, same word -> 0x0000_80FF.
REQ-035 Bench SHALL cover stall: stall held 3 cycles while 2 entries arrive -> in_ready 0 after the second; on release, entries commit in order on 2 consecutive cycles.
REQ-036 Bench SHALL cover x0 and no-write: rd 0, sel 0 -> rf_wen 0, commit_valid 1; sel 3 -> no write, retire_cnt increments.
REQ-037 Bench SHALL cover illegal load: funct3 111 -> wdata 0, ld_err 1 sticky until rst.
REQ-038 Bench SHALL cover reset mid-stream: rst asserted with S and K full -> no rf_wen, retire_cnt 0, in_ready 1 in the cycle after release.
